gru_gate_scheduler: RTL and testbench

GRU_GATE_SCHEDULER -- requirements
Module: gru_gate_scheduler

---
 rtl/gru_pkg.sv | 24 ++
 rtl/gru_lane_arbiter.sv | 13 +
 rtl/gru_gate_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_gru_gate_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gru_pkg.sv
// Shared types for the GRU gate scheduler: gate encoding, scheduler states, index-width helper.
package gru_pkg;

  typedef enum logic [1:0] {
    GATE_R = 2'd0,
    GATE_Z = 2'd1,
    GATE_N = 2'd2
  } gate_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_RZ = 3'd1,
    DRAIN_RZ = 3'd2,
    ISSUE_N  = 3'd3,
    DRAIN_N  = 3'd4,
    DONE     = 3'd5
  } sched_state_t;

  // An index bus is kept at least one bit wide so H=1 still has a legal port.
  function automatic int idx_w(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/gru_lane_arbiter.sv
// Fixed-priority finder: one-hot grant of the lowest-index asserted request, combinational.
module gru_lane_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  assign gnt_o = req_i & (~req_i + N'(1));
  assign any_o = |req_i;

endmodule

// File: rtl/gru_gate_scheduler.sv
// Schedules one GRU timestep: R/Z jobs interleaved by index, drain, then N jobs, drain, done.
// Jobs go to the lowest free lane; lane results are written back one per cycle, lowest lane first.
module gru_gate_scheduler
  import gru_pkg::*;
#(
  parameter int H          = 256,
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_LANES-1:0]            lane_valid_in,
  output logic [1:0]                      issue_gate,
  output logic [idx_w(H)-1:0]             issue_idx,
  input  logic [NUM_LANES-1:0]            lane_valid_out,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_result,
  output logic                            res_we,
  output logic [1:0]                      res_gate,
  output logic [idx_w(H)-1:0]             res_idx,
  output logic [DATA_WIDTH-1:0]           res_data,
  output logic                            err
);

  localparam int L  = NUM_LANES;
  localparam int IW = idx_w(H);
  localparam int CW = $clog2(2 * H + 1);
  localparam logic [CW-1:0] RZ_JOBS = CW'(2 * H);
  localparam logic [CW-1:0] N_JOBS  = CW'(H);

  sched_state_t                   state_q;
  logic [CW-1:0]                  iss_cnt_q, ret_cnt_q;
  logic                           busy_q, done_q, err_q, res_we_q;
  logic [L-1:0]                   lane_vld_q;
  gate_t                          issue_gate_q, res_gate_q;
  logic [IW-1:0]                  issue_idx_q, res_idx_q;
  logic [DATA_WIDTH-1:0]          res_data_q;

  logic [L-1:0]                   lane_busy_q, lane_pend_q;
  logic [L-1:0][DATA_WIDTH-1:0]   pend_data_q;
  gate_t                          lane_gate_q [L];
  logic [IW-1:0]                  lane_idx_q  [L];

  logic [L-1:0]                   lane_free, iss_req, iss_gnt, wb_gnt, cap, bad;
  logic                           iss_any, wb_any, issuing;
  gate_t                          job_gate, wb_gate;
  logic [IW-1:0]                  job_idx, wb_idx;
  logic [DATA_WIDTH-1:0]          wb_data;

  assign lane_free = ~(lane_busy_q | lane_pend_q);
  assign issuing   = (state_q == ISSUE_RZ && iss_cnt_q != RZ_JOBS) ||
                     (state_q == ISSUE_N  && iss_cnt_q != N_JOBS);
  assign iss_req   = issuing ? lane_free : '0;
  assign cap       = lane_valid_out & lane_busy_q & ~lane_pend_q;
  assign bad       = lane_valid_out & ~cap;

  gru_lane_arbiter #(.N(L)) u_issue_arb (
    .req_i (iss_req),
    .gnt_o (iss_gnt),
    .any_o (iss_any)
  );

  gru_lane_arbiter #(.N(L)) u_wb_arb (
    .req_i (lane_pend_q),
    .gnt_o (wb_gnt),
    .any_o (wb_any)
  );

  // RZ issue count k maps to gate k[0], element k/2; N issue count maps to element k.
  always_comb begin
    job_gate = GATE_N;
    job_idx  = IW'(iss_cnt_q);
    if (state_q == ISSUE_RZ) begin
      job_gate = iss_cnt_q[0] ? GATE_Z : GATE_R;
      job_idx  = IW'(iss_cnt_q >> 1);
    end
  end

  always_comb begin
    wb_gate = GATE_R;
    wb_idx  = '0;
    wb_data = '0;
    for (int i = 0; i < L; i++) begin
      if (wb_gnt[i]) begin
        wb_gate = lane_gate_q[i];
        wb_idx  = lane_idx_q[i];
        wb_data = pend_data_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      iss_cnt_q    <= '0;
      ret_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      res_we_q     <= 1'b0;
      lane_vld_q   <= '0;
      issue_gate_q <= GATE_R;
      issue_idx_q  <= '0;
      res_gate_q   <= GATE_R;
      res_idx_q    <= '0;
      res_data_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      lane_vld_q <= iss_gnt;
      res_we_q   <= wb_any;
      if (|bad) err_q <= 1'b1;
      if (iss_any) begin
        iss_cnt_q    <= iss_cnt_q + CW'(1);
        issue_gate_q <= job_gate;
        issue_idx_q  <= job_idx;
      end
      if (wb_any) begin
        ret_cnt_q  <= ret_cnt_q + CW'(1);
        res_gate_q <= wb_gate;
        res_idx_q  <= wb_idx;
        res_data_q <= wb_data;
      end
      // Phase entries come last so their counter clears win.
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= ISSUE_RZ;
            busy_q    <= 1'b1;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
          end
        end
        ISSUE_RZ: if (iss_cnt_q == RZ_JOBS) state_q <= DRAIN_RZ;
        DRAIN_RZ: begin
          if (ret_cnt_q == RZ_JOBS) begin
            state_q   <= ISSUE_N;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
          end
        end
        ISSUE_N: if (iss_cnt_q == N_JOBS) state_q <= DRAIN_N;
        DRAIN_N: begin
          if (ret_cnt_q == N_JOBS) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_busy_q <= '0;
      lane_pend_q <= '0;
      pend_data_q <= '0;
      for (int i = 0; i < L; i++) begin
        lane_gate_q[i] <= GATE_R;
        lane_idx_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < L; i++) begin
        if (iss_gnt[i]) begin
          lane_busy_q[i] <= 1'b1;
          lane_gate_q[i] <= job_gate;
          lane_idx_q[i]  <= job_idx;
        end
        if (cap[i]) begin
          lane_busy_q[i] <= 1'b0;
          lane_pend_q[i] <= 1'b1;
          pend_data_q[i] <= lane_result[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (wb_gnt[i]) lane_pend_q[i] <= 1'b0;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign lane_valid_in = lane_vld_q;
  assign issue_gate    = issue_gate_q;
  assign issue_idx     = issue_idx_q;
  assign res_we        = res_we_q;
  assign res_gate      = res_gate_q;
  assign res_idx       = res_idx_q;
  assign res_data      = res_data_q;

endmodule

// File: tb/tb_gru_gate_scheduler.sv
// Directed bench: H=4/2-lane and H=1/4-lane schedulers with a 3-cycle lane responder.
module tb_gru_gate_scheduler;
  import gru_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: H=4, 2 lanes
  logic        a_rst, a_start, a_busy, a_done, a_we, a_err;
  logic [1:0]  a_lvi, a_lvo, a_igate, a_rgate, a_iidx, a_ridx;
  logic [31:0] a_lres;
  logic [15:0] a_rdata;

  gru_gate_scheduler #(.H(4), .NUM_LANES(2), .DATA_WIDTH(16)) u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .busy(a_busy), .done(a_done),
    .lane_valid_in(a_lvi), .issue_gate(a_igate), .issue_idx(a_iidx),
    .lane_valid_out(a_lvo), .lane_result(a_lres),
    .res_we(a_we), .res_gate(a_rgate), .res_idx(a_ridx), .res_data(a_rdata), .err(a_err)
  );

  // Instance B: H=1, 4 lanes
  logic        b_rst, b_start, b_busy, b_done, b_we, b_err;
  logic [3:0]  b_lvi, b_lvo;
  logic [1:0]  b_igate, b_rgate;
  logic [0:0]  b_iidx, b_ridx;
  logic [63:0] b_lres;
  logic [15:0] b_rdata;

  gru_gate_scheduler #(.H(1), .NUM_LANES(4), .DATA_WIDTH(16)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
    .lane_valid_in(b_lvi), .issue_gate(b_igate), .issue_idx(b_iidx),
    .lane_valid_out(b_lvo), .lane_result(b_lres),
    .res_we(b_we), .res_gate(b_rgate), .res_idx(b_ridx), .res_data(b_rdata), .err(b_err)
  );

  // Bench-side lane model state
  bit          a_auto;
  int          a_cnt [2];
  logic [1:0]  a_lg [2];
  logic [1:0]  a_li [2];
  logic [19:0] a_wlog [$];
  int          a_dones, a_issues;
  int          b_cnt [4];
  logic [1:0]  b_lg [4];
  logic [0:0]  b_li [4];
  logic [19:0] b_wlog [$];
  int          b_dones, b_nlane;
  bit          b_hi;

  function automatic logic [15:0] res_of(input logic [1:0] g, input logic [7:0] i);
    return {4'h5, 2'b00, g, i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge, log outputs, run the lane responders.
  task automatic tick();
    @(negedge clk);
    if (a_we) a_wlog.push_back({a_rgate, a_ridx, a_rdata});
    if (a_done) a_dones++;
    if (a_auto) begin
      a_lvo = '0;
      for (int i = 0; i < 2; i++) begin
        if (a_cnt[i] > 0) begin
          a_cnt[i]--;
          if (a_cnt[i] == 0) begin
            a_lvo[i] = 1'b1;
            a_lres[i*16 +: 16] = res_of(a_lg[i], {6'b0, a_li[i]});
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (a_lvi[i]) begin
        a_lg[i] = a_igate;
        a_li[i] = a_iidx;
        a_issues++;
        if (a_auto) a_cnt[i] = 3;
      end
    end
    if (b_we) b_wlog.push_back({b_rgate, 1'b0, b_ridx, b_rdata});
    if (b_done) b_dones++;
    if (b_lvi[3:2] != 2'b00) b_hi = 1'b1;
    b_lvo = '0;
    for (int i = 0; i < 4; i++) begin
      if (b_cnt[i] > 0) begin
        b_cnt[i]--;
        if (b_cnt[i] == 0) begin
          b_lvo[i] = 1'b1;
          b_lres[i*16 +: 16] = res_of(b_lg[i], {7'b0, b_li[i]});
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (b_lvi[i]) begin
        b_lg[i]  = b_igate;
        b_li[i]  = b_iidx;
        b_cnt[i] = 3;
        if (b_igate == 2'd2) b_nlane = i;
      end
    end
  endtask

  task automatic check_a_zero(input string p);
    chk({p, "_busy"},  32'(a_busy),  32'd0);
    chk({p, "_done"},  32'(a_done),  32'd0);
    chk({p, "_lvi"},   32'(a_lvi),   32'd0);
    chk({p, "_igate"}, 32'(a_igate), 32'd0);
    chk({p, "_iidx"},  32'(a_iidx),  32'd0);
    chk({p, "_we"},    32'(a_we),    32'd0);
    chk({p, "_rgate"}, 32'(a_rgate), 32'd0);
    chk({p, "_ridx"},  32'(a_ridx),  32'd0);
    chk({p, "_rdata"}, 32'(a_rdata), 32'd0);
    chk({p, "_err"},   32'(a_err),   32'd0);
  endtask

  // Full timestep on A; expected write order is R0 Z0 R1 Z1 R2 Z2 R3 Z3 N0 N1 N2 N3.
  task automatic run_a(input string p, input bit poke);
    bit          poked, seen_busy;
    logic [1:0]  g;
    logic [1:0]  ix;
    logic [19:0] ex;
    a_wlog.delete();
    a_dones   = 0;
    a_auto    = 1'b1;
    poked     = 1'b0;
    seen_busy = 1'b0;
    a_start   = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 400 && a_dones == 0; c++) begin
      tick();
      if (a_busy) seen_busy = 1'b1;
      if (poke && !poked && a_lvi != 2'b00 && a_igate == 2'd2) begin
        a_start = 1'b1;
        poked   = 1'b1;
      end else begin
        a_start = 1'b0;
      end
    end
    a_start = 1'b0;
    repeat (3) tick();
    chk({p, "_dones"}, 32'(a_dones), 32'd1);
    chk({p, "_seen_busy"}, 32'(seen_busy), 32'd1);
    chk({p, "_busy_after"}, 32'(a_busy), 32'd0);
    chk({p, "_err"}, 32'(a_err), 32'd0);
    if (poke) chk({p, "_poked"}, 32'(poked), 32'd1);
    chk({p, "_nwrites"}, 32'(a_wlog.size()), 32'd12);
    for (int k = 0; k < 12; k++) begin
      g  = (k < 8) ? 2'(k % 2) : 2'd2;
      ix = (k < 8) ? 2'(k / 2) : 2'(k - 8);
      ex = {g, ix, res_of(g, {6'b0, ix})};
      chk($sformatf("%s_w%0d", p, k), (k < a_wlog.size()) ? 32'(a_wlog[k]) : 32'hFFFF_FFFF, 32'(ex));
    end
  endtask

  initial begin
    int wsz;
    a_rst = 1'b1; a_start = 1'b0; a_lvo = '0; a_lres = '0; a_auto = 1'b1;
    b_rst = 1'b1; b_start = 1'b0; b_lvo = '0; b_lres = '0;
    a_dones = 0; a_issues = 0; b_dones = 0; b_nlane = -1; b_hi = 1'b0;
    for (int i = 0; i < 2; i++) begin a_cnt[i] = 0; a_lg[i] = '0; a_li[i] = '0; end
    for (int i = 0; i < 4; i++) begin b_cnt[i] = 0; b_lg[i] = '0; b_li[i] = '0; end
    tick();
    check_a_zero("reset");
    chk("reset_b_busy", 32'(b_busy), 32'd0);
    chk("reset_b_err", 32'(b_err), 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    run_a("full", 1'b0);

    // Stray completion on an idle lane while idle
    a_auto = 1'b0;
    a_wlog.delete();
    a_lvo = 2'b01;
    tick();
    a_lvo = 2'b00;
    tick();
    chk("stray_err", 32'(a_err), 32'd1);
    chk("stray_we", 32'(a_wlog.size()), 32'd0);
    repeat (5) tick();
    chk("stray_err_hold", 32'(a_err), 32'd1);
    a_rst = 1'b1;
    tick();
    chk("stray_err_clr", 32'(a_err), 32'd0);
    a_rst = 1'b0;
    tick();

    run_a("poke", 1'b1);

    // Simultaneous completion on both lanes
    a_auto   = 1'b0;
    a_issues = 0;
    a_wlog.delete();
    a_start  = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 20 && a_issues < 2; c++) tick();
    chk("sim_issued", 32'(a_issues), 32'd2);
    a_lres = {res_of(a_lg[1], {6'b0, a_li[1]}), res_of(a_lg[0], {6'b0, a_li[0]})};
    a_lvo  = 2'b11;
    tick();
    a_lvo = 2'b00;
    chk("sim_t0_we", 32'(a_we), 32'd0);
    tick();
    chk("sim_t1_we", 32'(a_we), 32'd1);
    chk("sim_t1_wr", {a_rgate, a_ridx, a_rdata}, {2'd0, 2'd0, res_of(2'd0, 8'd0)});
    chk("sim_t1_lvi", 32'(a_lvi), 32'd0);
    tick();
    chk("sim_t2_we", 32'(a_we), 32'd1);
    chk("sim_t2_wr", {a_rgate, a_ridx, a_rdata}, {2'd1, 2'd0, res_of(2'd1, 8'd0)});
    chk("sim_t2_lvi", 32'(a_lvi), 32'd1);
    tick();
    chk("sim_t3_lvi", 32'(a_lvi), 32'd2);
    chk("sim_t3_we", 32'(a_we), 32'd0);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    tick();

    // Reset with two RZ jobs in flight
    a_auto   = 1'b1;
    a_issues = 0;
    a_start  = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 200 && a_issues < 8; c++) tick();
    chk("mid_issued", 32'(a_issues), 32'd8);
    tick();
    wsz   = a_wlog.size();
    a_rst = 1'b1;
    tick();
    check_a_zero("mid_rst");
    a_rst = 1'b0;
    repeat (6) tick();
    chk("mid_late_err", 32'(a_err), 32'd1);
    chk("mid_no_write", 32'(a_wlog.size()), 32'(wsz));
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk("mid_err_clr", 32'(a_err), 32'd0);
    tick();
    run_a("rerun", 1'b0);

    // H=1 on four lanes
    b_wlog.delete();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 0; c < 200 && b_dones == 0; c++) tick();
    repeat (3) tick();
    chk("h1_dones", 32'(b_dones), 32'd1);
    chk("h1_busy", 32'(b_busy), 32'd0);
    chk("h1_err", 32'(b_err), 32'd0);
    chk("h1_upper_lanes", 32'(b_hi), 32'd0);
    chk("h1_n_lane", 32'(b_nlane), 32'd0);
    chk("h1_nwrites", 32'(b_wlog.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("h1_w%0d", k), (k < b_wlog.size()) ? 32'(b_wlog[k]) : 32'hFFFF_FFFF,
          32'({2'(k), 2'b00, res_of(2'(k), 8'd0)}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
